// File: rtl/ex_wb_stage_buf_pkg.sv
// Shared types and default widths for the EX->WB boundary buffer.
// Provides exwb_entry_t {alu, rd, regwrite} at the default widths.
package ex_wb_pkg;

  localparam int EXWB_DATA_W = 8;
  localparam int EXWB_RD_W   = 3;

  typedef struct packed {
    logic [EXWB_DATA_W-1:0] alu;
    logic [EXWB_RD_W-1:0]   rd;
    logic                   regwrite;
  } exwb_entry_t;

endpackage

// File: rtl/ex_wb_stage_buf_if.sv
// EX->WB handshake bundle: ex_* valid/ready producer side, wb_* consumer side.
// slave = the stage buffer, master = the surrounding EX/WB logic.
interface ex_wb_stage_buf_if
  import ex_wb_pkg::*;
#(
  parameter int DATA_W = EXWB_DATA_W,
  parameter int RD_W   = EXWB_RD_W
);

  logic              ex_valid;
  logic              ex_ready;
  logic [DATA_W-1:0] ex_alu;
  logic [RD_W-1:0]   ex_rd;
  logic              ex_regwrite;
  logic              wb_valid;
  logic              wb_ready;
  logic [DATA_W-1:0] wb_alu;
  logic [RD_W-1:0]   wb_rd;
  logic              wb_we;

  modport slave (
    input  ex_valid, ex_alu, ex_rd, ex_regwrite, wb_ready,
    output ex_ready, wb_valid, wb_alu, wb_rd, wb_we
  );

  modport master (
    output ex_valid, ex_alu, ex_rd, ex_regwrite, wb_ready,
    input  ex_ready, wb_valid, wb_alu, wb_rd, wb_we
  );

endinterface

// File: rtl/ex_wb_stage_buf_skid_reg.sv
// exwb_skid_reg: one valid bit plus W-bit payload with load/clear.
// Ports: clk, rst_n, i_clr (wins), i_load, i_data -> o_valid, o_data.
module exwb_skid_reg #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  // Clear only drops the valid bit; payload may stay stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/ex_wb_stage_buf.sv
// EX->WB elastic boundary: output register plus one skid slot, FIFO order.
// Ports: clock, reset (async low), flush, bus (slave); EX_WB_FWD_EN adds fwd_*.
module ex_wb_stage_buf
  import ex_wb_pkg::*;
#(
  parameter int DATA_W = EXWB_DATA_W,
  parameter int RD_W   = EXWB_RD_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  ex_wb_stage_buf_if.slave  bus
`ifdef EX_WB_FWD_EN
  ,
  input  logic [RD_W-1:0]   fwd_rs,
  input  logic [RD_W-1:0]   fwd_rt,
  output logic              fwd_hit_rs,
  output logic              fwd_hit_rt,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  localparam int EW = DATA_W + RD_W + 1;

  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [RD_W-1:0]   rd;
    logic              regwrite;
  } entry_t;

  entry_t w_in;
  entry_t w_skid;
  entry_t w_out;
  entry_t w_out_d;
  logic   w_skid_v;
  logic   w_out_v;
  logic   w_ex_fire;
  logic   w_out_free;
  logic   w_out_load;
  logic   w_out_clr;
  logic   w_skid_load;
  logic   w_skid_clr;

  assign w_in = '{
    alu:      bus.ex_alu,
    rd:       bus.ex_rd,
    regwrite: bus.ex_regwrite
  };

  // ex_ready comes only from skid state, so no wb_ready->ex_ready path.
  assign w_ex_fire  = bus.ex_valid & ~w_skid_v;
  assign w_out_free = ~w_out_v | bus.wb_ready;

  // While the skid holds an entry EX is stalled, so the output
  // refills from the skid; otherwise straight from EX.
  assign w_out_load = ~flush &
    (w_skid_v ? bus.wb_ready : (w_out_free & w_ex_fire));
  assign w_out_clr  = flush | (bus.wb_ready & ~w_out_load);
  assign w_out_d    = w_skid_v ? w_skid : w_in;

  assign w_skid_load = ~flush & w_ex_fire & ~w_out_free;
  assign w_skid_clr  = flush | (w_skid_v & bus.wb_ready);

  exwb_skid_reg #(.W(EW)) u_skid (
    .clk     (clock),
    .rst_n   (reset),
    .i_clr   (w_skid_clr),
    .i_load  (w_skid_load),
    .i_data  (w_in),
    .o_valid (w_skid_v),
    .o_data  (w_skid)
  );

  exwb_skid_reg #(.W(EW)) u_out (
    .clk     (clock),
    .rst_n   (reset),
    .i_clr   (w_out_clr),
    .i_load  (w_out_load),
    .i_data  (w_out_d),
    .o_valid (w_out_v),
    .o_data  (w_out)
  );

  assign bus.ex_ready = ~w_skid_v;
  assign bus.wb_valid = w_out_v;
  assign bus.wb_alu   = w_out.alu;
  assign bus.wb_rd    = w_out.rd;
  assign bus.wb_we    = w_out_v & w_out.regwrite;

`ifdef EX_WB_FWD_EN
  // Only the output slot forwards; the skid entry is younger.
  assign fwd_hit_rs = bus.wb_we & (w_out.rd == fwd_rs);
  assign fwd_hit_rt = bus.wb_we & (w_out.rd == fwd_rt);
  assign fwd_data   = w_out.alu;
`endif

endmodule
